// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch/trap redirect path: state encoding,
// redirect source flags and default widths reused by BranchUnit.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    IDLE     = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  localparam logic SRC_BRANCH = 1'b0;
  localparam logic SRC_TRAP   = 1'b1;

  localparam int unsigned   ADDR_WIDTH   = 64;
  localparam logic [63:0]   RESET_VECTOR = 64'h0;
  localparam int unsigned   FLUSH_CYCLES = 3;
  localparam int unsigned   COUNT_WIDTH  = 32;
  localparam int unsigned   TIMER_WIDTH  = 4;

  // Timer reload value so that flush_o stays high for exactly n cycles.
  function automatic logic [TIMER_WIDTH-1:0] flush_reload(input int unsigned n);
    flush_reload = TIMER_WIDTH'(n - 1);
  endfunction

endpackage

// File: rtl/branch_redirect_sequencer_flush_timer.sv
// Loadable down-counter that paces the pipeline flush; done_o flags zero.
module flush_timer
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned Width = TIMER_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  // Load has priority over decrement; the counter saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != {Width{1'b0}})) begin
      count_d = count_q - {{(Width-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {Width{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == {Width{1'b0}});

endmodule

// File: rtl/branch_redirect_sequencer.sv
// Sequences boot, branch and trap redirects to fetch: arbitration, fixed-length
// flush, valid/ready hand-off of the target PC and a completed-redirect counter.
module branch_redirect_sequencer
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned              addressWidth = ADDR_WIDTH,
  parameter logic [addressWidth-1:0]  resetVector  = addressWidth'(RESET_VECTOR),
  parameter int unsigned              flushCycles  = FLUSH_CYCLES,
  parameter int unsigned              countWidth   = COUNT_WIDTH
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    branchValid_i,
  input  logic [addressWidth-1:0] branchTarget_i,
  input  logic                    trapValid_i,
  input  logic [addressWidth-1:0] trapTarget_i,
  input  logic                    fetchReady_i,
  output logic                    flush_o,
  output logic                    stall_o,
  output logic                    redirectValid_o,
  output logic [addressWidth-1:0] redirectPC_o,
  output logic [countWidth-1:0]   redirectCount_o
);

  localparam logic [TIMER_WIDTH-1:0] FlushReload = flush_reload(flushCycles);

  state_e                  state_q, state_d;
  logic                    flush_q, flush_d;
  logic                    stall_q, stall_d;
  logic                    valid_q, valid_d;
  logic [addressWidth-1:0] pc_q, pc_d;
  logic [addressWidth-1:0] target_q, target_d;
  logic                    src_q, src_d;
  logic [countWidth-1:0]   count_q, count_d;

  logic handshake_s;
  logic trap_preempt_s;
  logic load_s;
  logic dec_s;
  logic timer_done_s;

  assign handshake_s    = valid_q & fetchReady_i;
  // Only a branch-sourced redirect may be pre-empted; a pending trap is final.
  assign trap_preempt_s = trapValid_i & (src_q == SRC_BRANCH);

  flush_timer #(.Width(TIMER_WIDTH)) u_flush_timer (
    .clk_i   (clock_i),
    .rst_ni  (reset_i),
    .load_i  (load_s),
    .value_i (FlushReload),
    .dec_i   (dec_s),
    .done_o  (timer_done_s)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    stall_d  = stall_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    target_d = target_q;
    src_d    = src_q;
    count_d  = count_q;
    load_s   = 1'b0;
    dec_s    = 1'b0;
    case (state_q)
      BOOT: begin
        if (handshake_s) begin
          state_d = IDLE;
          valid_d = 1'b0;
          stall_d = 1'b0;
        end else if (trapValid_i) begin
          valid_d = 1'b1;
          pc_d    = trapTarget_i;
        end else begin
          valid_d = 1'b1;
        end
      end
      IDLE: begin
        if (trapValid_i || branchValid_i) begin
          state_d = FLUSH;
          flush_d = 1'b1;
          stall_d = 1'b1;
          load_s  = 1'b1;
          if (trapValid_i) begin
            target_d = trapTarget_i;
            src_d    = SRC_TRAP;
          end else begin
            target_d = branchTarget_i;
            src_d    = SRC_BRANCH;
          end
        end else begin
          flush_d = 1'b0;
          stall_d = 1'b0;
        end
      end
      FLUSH: begin
        if (trap_preempt_s) begin
          target_d = trapTarget_i;
          src_d    = SRC_TRAP;
          load_s   = 1'b1;
        end else if (timer_done_s) begin
          state_d = REDIRECT;
          flush_d = 1'b0;
          valid_d = 1'b1;
          pc_d    = target_q;
        end else begin
          dec_s = 1'b1;
        end
      end
      REDIRECT: begin
        // A handshake in the same cycle as a pre-empting trap still counts.
        if (handshake_s) begin
          count_d = count_q + {{(countWidth-1){1'b0}}, 1'b1};
        end else begin
          count_d = count_q;
        end
        if (trap_preempt_s) begin
          state_d  = FLUSH;
          flush_d  = 1'b1;
          valid_d  = 1'b0;
          target_d = trapTarget_i;
          src_d    = SRC_TRAP;
          load_s   = 1'b1;
        end else if (handshake_s) begin
          state_d = IDLE;
          valid_d = 1'b0;
          stall_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
        flush_d = 1'b0;
        stall_d = 1'b1;
        valid_d = 1'b0;
        pc_d    = resetVector;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= BOOT;
      flush_q  <= 1'b0;
      stall_q  <= 1'b1;
      valid_q  <= 1'b0;
      pc_q     <= resetVector;
      target_q <= resetVector;
      src_q    <= SRC_BRANCH;
      count_q  <= {countWidth{1'b0}};
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      stall_q  <= stall_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      src_q    <= src_d;
      count_q  <= count_d;
    end
  end

  assign flush_o         = flush_q;
  assign stall_o         = stall_q;
  assign redirectValid_o = valid_q;
  assign redirectPC_o    = pc_q;
  assign redirectCount_o = count_q;

endmodule

// File: tb/tb_branch_redirect_sequencer.sv
// Randomised and directed bench for branch_redirect_sequencer against a
// phase/remaining-cycles reference model.
module tb_branch_redirect_sequencer;

  localparam int unsigned AW = 64;
  localparam int unsigned FC = 3;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] RV = 64'h0;

  localparam int P_BOOT = 0;
  localparam int P_IDLE = 1;
  localparam int P_FLUSH = 2;
  localparam int P_REDIR = 3;

  logic clock = 1'b0;
  logic reset_n;
  logic br, tr, rdy;
  logic [AW-1:0] bt, tt;
  logic flush_o, stall_o, redirectValid_o;
  logic [AW-1:0] redirectPC_o;
  logic [CW-1:0] redirectCount_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_phase;
  int m_left;
  bit m_trap;
  logic [AW-1:0] m_target, m_pc;
  logic m_valid;
  logic [CW-1:0] m_count;
  logic m_flush, m_stall;

  branch_redirect_sequencer #(
    .addressWidth(AW), .resetVector(RV), .flushCycles(FC), .countWidth(CW)
  ) dut (
    .clock_i(clock), .reset_i(reset_n),
    .branchValid_i(br), .branchTarget_i(bt),
    .trapValid_i(tr), .trapTarget_i(tt),
    .fetchReady_i(rdy),
    .flush_o(flush_o), .stall_o(stall_o),
    .redirectValid_o(redirectValid_o), .redirectPC_o(redirectPC_o),
    .redirectCount_o(redirectCount_o)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_phase = P_BOOT; m_left = 0; m_trap = 1'b0;
    m_target = RV; m_pc = RV; m_valid = 1'b0; m_count = '0;
    m_flush = 1'b0; m_stall = 1'b1;
  endtask

  task automatic model_step();
    bit hs;
    hs = m_valid && rdy;
    case (m_phase)
      P_BOOT: begin
        if (hs) begin m_phase = P_IDLE; m_valid = 1'b0; end
        else begin m_valid = 1'b1; if (tr) m_pc = tt; end
      end
      P_IDLE: begin
        if (tr) begin m_target = tt; m_trap = 1'b1; m_phase = P_FLUSH; m_left = FC; end
        else if (br) begin m_target = bt; m_trap = 1'b0; m_phase = P_FLUSH; m_left = FC; end
      end
      P_FLUSH: begin
        if (tr && !m_trap) begin m_target = tt; m_trap = 1'b1; m_left = FC; end
        else begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = P_REDIR; m_valid = 1'b1; m_pc = m_target; end
        end
      end
      default: begin
        if (hs) m_count = m_count + 1'b1;
        if (tr && !m_trap) begin
          m_target = tt; m_trap = 1'b1; m_phase = P_FLUSH; m_left = FC; m_valid = 1'b0;
        end else if (hs) begin
          m_phase = P_IDLE; m_valid = 1'b0;
        end
      end
    endcase
    m_flush = (m_phase == P_FLUSH);
    m_stall = (m_phase != P_IDLE);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; br = 0; tr = 0; rdy = 0; bt = '0; tt = '0;
    model_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (flush_o !== 1'b0 || stall_o !== 1'b1 || redirectValid_o !== 1'b0 ||
        redirectPC_o !== RV || redirectCount_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: got f%b s%b v%b pc=%h n=%0d, want f0 s1 v0 pc=%h n=0",
               flush_o, stall_o, redirectValid_o, redirectPC_o, redirectCount_o, RV);
    end
  endtask

  task automatic test_boot();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdy = (i >= 2);
      tick();
      checks++;
      if (flush_o !== m_flush || stall_o !== m_stall || redirectValid_o !== m_valid ||
          redirectPC_o !== m_pc || redirectCount_o !== m_count) begin
        errors++;
        $display("FAIL boot cyc%0d: got f%b s%b v%b pc=%h n=%0d want f%b s%b v%b pc=%h n=%0d",
                 i, flush_o, stall_o, redirectValid_o, redirectPC_o, redirectCount_o,
                 m_flush, m_stall, m_valid, m_pc, m_count);
      end
      if (i < 2) begin
        checks++;
        if (redirectValid_o !== 1'b1 || redirectPC_o !== RV) begin
          errors++;
          $display("FAIL boot_valid cyc%0d: got v%b pc=%h want v1 pc=%h", i, redirectValid_o, redirectPC_o, RV);
        end
      end
    end
    checks++;
    if (stall_o !== 1'b0 || redirectValid_o !== 1'b0 || redirectCount_o !== 8'd0) begin
      errors++;
      $display("FAIL boot_idle: got s%b v%b n=%0d want s0 v0 n=0", stall_o, redirectValid_o, redirectCount_o);
    end
  endtask

  // Single redirect with ready held high; checks flush length, target and count.
  task automatic run_single(input string nm, input logic b, input logic [AW-1:0] btgt,
                            input logic t, input logic [AW-1:0] ttgt,
                            input logic [AW-1:0] want_pc);
    int nflush, nvalid;
    logic [AW-1:0] seen_pc;
    logic [CW-1:0] cnt0;
    nflush = 0; nvalid = 0; seen_pc = '1; cnt0 = redirectCount_o;
    rdy = 1'b1;
    br = b; bt = btgt; tr = t; tt = ttgt;
    for (int i = 0; i < 9; i++) begin
      tick();
      br = 1'b0; tr = 1'b0;
      nflush += int'(flush_o);
      if (redirectValid_o) begin nvalid++; seen_pc = redirectPC_o; end
      checks++;
      if (flush_o !== m_flush || stall_o !== m_stall || redirectValid_o !== m_valid ||
          redirectPC_o !== m_pc || redirectCount_o !== m_count) begin
        errors++;
        $display("FAIL %s cyc%0d: got f%b s%b v%b pc=%h n=%0d want f%b s%b v%b pc=%h n=%0d",
                 nm, i, flush_o, stall_o, redirectValid_o, redirectPC_o, redirectCount_o,
                 m_flush, m_stall, m_valid, m_pc, m_count);
      end
    end
    checks++;
    if (nflush != FC || nvalid != 1 || seen_pc !== want_pc ||
        redirectCount_o !== cnt0 + 8'd1 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_summary: got flush=%0d valid=%0d pc=%h n=%0d s%b want flush=%0d valid=1 pc=%h n=%0d s0",
               nm, nflush, nvalid, seen_pc, redirectCount_o, stall_o, FC, want_pc, cnt0 + 8'd1);
    end
  endtask

  task automatic test_branch();
    run_single("branch", 1'b1, 64'h1000, 1'b0, 64'h0, 64'h1000);
  endtask

  task automatic test_simultaneous();
    run_single("simul", 1'b1, 64'h2000, 1'b1, 64'h700, 64'h700);
  endtask

  task automatic test_trap_restart();
    int nflush;
    logic [AW-1:0] seen_pc;
    logic [CW-1:0] cnt0;
    nflush = 0; seen_pc = '1; cnt0 = redirectCount_o;
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      br = (i == 0); bt = 64'h3000;
      tr = (i == 2); tt = 64'h900;
      tick();
      nflush += int'(flush_o);
      if (redirectValid_o) seen_pc = redirectPC_o;
      checks++;
      if (flush_o !== m_flush || stall_o !== m_stall || redirectValid_o !== m_valid ||
          redirectPC_o !== m_pc || redirectCount_o !== m_count) begin
        errors++;
        $display("FAIL restart cyc%0d: got f%b s%b v%b pc=%h n=%0d want f%b s%b v%b pc=%h n=%0d",
                 i, flush_o, stall_o, redirectValid_o, redirectPC_o, redirectCount_o,
                 m_flush, m_stall, m_valid, m_pc, m_count);
      end
    end
    br = 1'b0; tr = 1'b0;
    checks++;
    if (nflush != FC + 2 || seen_pc !== 64'h900 || redirectCount_o !== cnt0 + 8'd1) begin
      errors++;
      $display("FAIL restart_summary: got flush=%0d pc=%h n=%0d want flush=%0d pc=900 n=%0d",
               nflush, seen_pc, redirectCount_o, FC + 2, cnt0 + 8'd1);
    end
  endtask

  task automatic test_hold();
    logic [CW-1:0] cnt0;
    int guard;
    cnt0 = redirectCount_o;
    rdy = 1'b0;
    br = 1'b1; bt = 64'h5000;
    tick();
    br = 1'b0;
    guard = 0;
    while (m_phase != P_REDIR && guard < 10) begin tick(); guard++; end
    checks++;
    if (m_phase != P_REDIR) begin
      errors++;
      $display("FAIL hold_reach: redirect not reached within %0d cycles", guard);
    end
    for (int i = 0; i < 4; i++) begin
      br = i[0]; bt = {$urandom, $urandom};
      tick();
      checks++;
      if (redirectValid_o !== 1'b1 || redirectPC_o !== 64'h5000 || stall_o !== 1'b1 ||
          flush_o !== 1'b0 || redirectCount_o !== cnt0) begin
        errors++;
        $display("FAIL hold cyc%0d: got v%b pc=%h s%b f%b n=%0d want v1 pc=5000 s1 f0 n=%0d",
                 i, redirectValid_o, redirectPC_o, stall_o, flush_o, redirectCount_o, cnt0);
      end
    end
    br = 1'b0; rdy = 1'b1;
    tick();
    checks++;
    if (redirectValid_o !== 1'b0 || stall_o !== 1'b0 || redirectCount_o !== cnt0 + 8'd1) begin
      errors++;
      $display("FAIL hold_release: got v%b s%b n=%0d want v0 s0 n=%0d",
               redirectValid_o, stall_o, redirectCount_o, cnt0 + 8'd1);
    end
  endtask

  task automatic drain();
    int guard;
    br = 1'b0; tr = 1'b0; rdy = 1'b1;
    guard = 0;
    while (m_phase != P_IDLE && guard < 40) begin tick(); guard++; end
    checks++;
    if (m_phase != P_IDLE || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL drain: got stall=%b after %0d cycles want 0", stall_o, guard);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      br = ($urandom_range(0, 99) < 30);
      tr = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 60);
      bt = {$urandom, $urandom};
      tt = {$urandom, $urandom};
      tick();
      checks++;
      if (flush_o !== m_flush || stall_o !== m_stall || redirectValid_o !== m_valid ||
          redirectPC_o !== m_pc || redirectCount_o !== m_count) begin
        errors++;
        $display("FAIL random cyc%0d: got f%b s%b v%b pc=%h n=%0d want f%b s%b v%b pc=%h n=%0d",
                 i, flush_o, stall_o, redirectValid_o, redirectPC_o, redirectCount_o,
                 m_flush, m_stall, m_valid, m_pc, m_count);
      end
    end
    drain();
  endtask

  task automatic one_redirect();
    br = 1'b1; bt = {$urandom, $urandom}; tr = 1'b0; rdy = 1'b1;
    tick();
    br = 1'b0;
    for (int g = 0; g < 10 && m_phase != P_IDLE; g++) tick();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 300 && m_count != 8'hFF; k++) one_redirect();
    checks++;
    if (redirectCount_o !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_pre: got n=%0d want 255", redirectCount_o);
    end
    one_redirect();
    checks++;
    if (redirectCount_o !== 8'h00 || m_count !== 8'h00) begin
      errors++;
      $display("FAIL wrap: got n=%0d want 0", redirectCount_o);
    end
  endtask

  task automatic test_async_reset();
    rdy = 1'b1; br = 1'b1; bt = 64'h4000;
    tick();
    br = 1'b0;
    tick();
    checks++;
    if (flush_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got f%b want f1", flush_o);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (flush_o !== 1'b0 || stall_o !== 1'b1 || redirectValid_o !== 1'b0 || redirectCount_o !== 8'd0) begin
      errors++;
      $display("FAIL areset: got f%b s%b v%b n=%0d want f0 s1 v0 n=0",
               flush_o, stall_o, redirectValid_o, redirectCount_o);
    end
    model_reset();
    rdy = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdy = (i == 2);
      tick();
      checks++;
      if (flush_o !== m_flush || stall_o !== m_stall || redirectValid_o !== m_valid ||
          redirectPC_o !== m_pc || redirectCount_o !== m_count) begin
        errors++;
        $display("FAIL areset_boot cyc%0d: got f%b s%b v%b pc=%h n=%0d want f%b s%b v%b pc=%h n=%0d",
                 i, flush_o, stall_o, redirectValid_o, redirectPC_o, redirectCount_o,
                 m_flush, m_stall, m_valid, m_pc, m_count);
      end
    end
    checks++;
    if (stall_o !== 1'b0 || redirectValid_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_idle: got s%b v%b want s0 v0", stall_o, redirectValid_o);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_branch();
    test_simultaneous();
    test_trap_restart();
    test_hold();
    test_random();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
